ram_256x8_access_pwr_ctrl: RTL



---
 rtl/ram_ctrl_pkg.sv | 19 +
 rtl/ram_256x8_pwr_seq.sv | 113 +++++++++++
 rtl/ram_256x8_access_pwr_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and sizes for the 256x8 RAM bank front-end controller.
// Holds the power FSM state enum and the bank geometry constants.
package ram_ctrl_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 8;
  localparam int SLEEP_BITS = 8;
  localparam int RD_LAT     = 1;

  typedef enum logic [2:0] {
    PWR_ACTIVE     = 3'd0,
    PWR_RET_ENTER  = 3'd1,
    PWR_SLEEP_RAMP = 3'd2,
    PWR_ASLEEP     = 3'd3,
    PWR_WAKE_RAMP  = 3'd4,
    PWR_RET_EXIT   = 3'd5
  } pwr_state_e;

endpackage

// File: rtl/ram_256x8_pwr_seq.sv
// Power sequencer: FSM, idle counter, ramp/guard counter, RET_EN/SLEEP_EN.
// Ports: i_clk/i_rst (sync, active-high), i_idle_thresh, i_force_sleep,
//   i_any_valid, i_busy (read in flight) -> o_active_ok, o_ret_en,
//   o_sleep_en, o_pwr_state.
module ram_256x8_pwr_seq
  import ram_ctrl_pkg::*;
#(
  parameter int IDLE_W     = 8,
  parameter int WAKE_GUARD = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [IDLE_W-1:0]     i_idle_thresh,
  input  logic                  i_force_sleep,
  input  logic                  i_any_valid,
  input  logic                  i_busy,
  output logic                  o_active_ok,
  output logic                  o_ret_en,
  output logic [SLEEP_BITS-1:0] o_sleep_en,
  output logic [2:0]            o_pwr_state
);

  localparam logic [3:0] RAMP_LAST  = 4'(SLEEP_BITS - 1);
  localparam logic [3:0] GUARD_LAST = 4'(WAKE_GUARD - 1);

  pwr_state_e            r_state;
  logic [IDLE_W-1:0]     r_idle_cnt;
  logic [3:0]            r_cnt;
  logic                  r_ret_en;
  logic [SLEEP_BITS-1:0] r_sleep_en;

  logic w_idle_hit;
  logic w_enter;

  assign w_idle_hit = (i_idle_thresh != '0) &&
                      (r_idle_cnt == i_idle_thresh);
  // Never drop into retention with a read still in flight.
  assign w_enter = (w_idle_hit || i_force_sleep) && !i_busy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idle_cnt <= '0;
    end else if (r_state != PWR_ACTIVE || i_any_valid) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt < i_idle_thresh) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= PWR_ACTIVE;
      r_cnt      <= '0;
      r_ret_en   <= 1'b0;
      r_sleep_en <= '0;
    end else begin
      unique case (r_state)
        PWR_ACTIVE: begin
          if (w_enter) begin
            r_state  <= PWR_RET_ENTER;
            r_ret_en <= 1'b1;
          end
        end
        PWR_RET_ENTER: begin
          r_state    <= PWR_SLEEP_RAMP;
          r_cnt      <= '0;
          r_sleep_en <= {{(SLEEP_BITS-1){1'b0}}, 1'b1};
        end
        PWR_SLEEP_RAMP: begin
          if (r_cnt == RAMP_LAST) begin
            r_state <= PWR_ASLEEP;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_sleep_en <= {r_sleep_en[SLEEP_BITS-2:0], 1'b1};
          end
        end
        PWR_ASLEEP: begin
          if (!i_force_sleep && i_any_valid) begin
            r_state    <= PWR_WAKE_RAMP;
            r_cnt      <= '0;
            r_sleep_en <= {1'b0, r_sleep_en[SLEEP_BITS-1:1]};
          end
        end
        PWR_WAKE_RAMP: begin
          if (r_cnt == RAMP_LAST) begin
            r_state  <= PWR_RET_EXIT;
            r_cnt    <= '0;
            r_ret_en <= 1'b0;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_sleep_en <= {1'b0, r_sleep_en[SLEEP_BITS-1:1]};
          end
        end
        PWR_RET_EXIT: begin
          if (r_cnt == GUARD_LAST) begin
            r_state <= PWR_ACTIVE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= PWR_ACTIVE;
        end
      endcase
    end
  end

  assign o_active_ok = (r_state == PWR_ACTIVE);
  assign o_ret_en    = r_ret_en;
  assign o_sleep_en  = r_sleep_en;
  assign o_pwr_state = r_state;

endmodule

// File: rtl/ram_256x8_access_pwr_ctrl.sv
// Front-end for one 256x8 DP RAM bank: 2 readers + 1 writer, 1-cycle reads,
// power sequencing. Optional macro RAM_256X8_CTRL_FWD_EN selects write->read
// forwarding on address collisions (default: write wins, reader stalls).
// Ports: nvdla_core_clk/rst, idle_thresh, pwr_force_sleep, rd0_*/rd1_*/wr_*
//   client handshakes, ram_* bank pins, pwr_state.
module ram_256x8_access_pwr_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int IDLE_W     = 8,
  parameter int WAKE_GUARD = 2
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic [IDLE_W-1:0]     idle_thresh,
  input  logic                  pwr_force_sleep,
  input  logic                  rd0_req_valid,
  output logic                  rd0_req_ready,
  input  logic [RAM_ADDR_W-1:0] rd0_req_addr,
  output logic                  rd0_resp_valid,
  output logic [RAM_DATA_W-1:0] rd0_resp_data,
  input  logic                  rd1_req_valid,
  output logic                  rd1_req_ready,
  input  logic [RAM_ADDR_W-1:0] rd1_req_addr,
  output logic                  rd1_resp_valid,
  output logic [RAM_DATA_W-1:0] rd1_resp_data,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [RAM_ADDR_W-1:0] wr_req_addr,
  input  logic [RAM_DATA_W-1:0] wr_req_data,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_ra,
  output logic [RAM_ADDR_W-1:0] ram_wa,
  output logic [RAM_DATA_W-1:0] ram_wd,
  input  logic [RAM_DATA_W-1:0] ram_rd,
  output logic                  ram_ret_en,
  output logic [SLEEP_BITS-1:0] ram_sleep_en,
  output logic [2:0]            pwr_state
);

  logic w_act;
  logic w_wr_acc;
  logic w_col0;
  logic w_col1;
  logic w_e0;
  logic w_e1;
  logic w_g0;
  logic w_g1;
  logic w_busy;
  logic w_any_valid;
  logic [RAM_DATA_W-1:0] w_rdata;

  logic r_rr;
  logic r_rv0;
  logic r_rv1;

  assign w_any_valid = rd0_req_valid | rd1_req_valid | wr_req_valid;
  assign w_wr_acc    = w_act && wr_req_valid;

`ifdef RAM_256X8_CTRL_FWD_EN
  logic                  r_fwd_hit;
  logic [RAM_DATA_W-1:0] r_fwd_data;

  assign w_col0 = 1'b0;
  assign w_col1 = 1'b0;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_hit  <= w_wr_acc &&
                    ((w_g0 && rd0_req_addr == wr_req_addr) ||
                     (w_g1 && rd1_req_addr == wr_req_addr));
      r_fwd_data <= wr_req_data;
    end
  end

  // The bank returns pre-write data on a collision, so substitute.
  assign w_rdata = r_fwd_hit ? r_fwd_data : ram_rd;
`else
  // Write wins: a reader hitting the write address waits a cycle.
  assign w_col0 = w_wr_acc && (rd0_req_addr == wr_req_addr);
  assign w_col1 = w_wr_acc && (rd1_req_addr == wr_req_addr);
  assign w_rdata = ram_rd;
`endif

  assign w_e0 = w_act && rd0_req_valid && !w_col0;
  assign w_e1 = w_act && rd1_req_valid && !w_col1;
  assign w_g0 = w_e0 && (!w_e1 || !r_rr);
  assign w_g1 = w_e1 && (!w_e0 || r_rr);

  assign rd0_req_ready = w_g0;
  assign rd1_req_ready = w_g1;
  assign wr_req_ready  = w_act;

  always_comb begin
    ram_ra = '0;
    unique case (1'b1)
      w_g0:    ram_ra = rd0_req_addr;
      w_g1:    ram_ra = rd1_req_addr;
      default: ram_ra = '0;
    endcase
  end

  assign ram_re = w_g0 | w_g1;
  assign ram_we = w_wr_acc;
  assign ram_wa = w_wr_acc ? wr_req_addr : '0;
  assign ram_wd = w_wr_acc ? wr_req_data : '0;

  assign w_busy = w_g0 | w_g1 | r_rv0 | r_rv1;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_rr  <= 1'b0;
      r_rv0 <= 1'b0;
      r_rv1 <= 1'b0;
    end else begin
      r_rv0 <= w_g0;
      r_rv1 <= w_g1;
      if (w_g0 || w_g1) begin
        r_rr <= ~r_rr;
      end
    end
  end

  assign rd0_resp_valid = r_rv0;
  assign rd1_resp_valid = r_rv1;
  assign rd0_resp_data  = r_rv0 ? w_rdata : '0;
  assign rd1_resp_data  = r_rv1 ? w_rdata : '0;

  ram_256x8_pwr_seq #(
    .IDLE_W     (IDLE_W),
    .WAKE_GUARD (WAKE_GUARD)
  ) u_pwr_seq (
    .i_clk         (nvdla_core_clk),
    .i_rst         (nvdla_core_rst),
    .i_idle_thresh (idle_thresh),
    .i_force_sleep (pwr_force_sleep),
    .i_any_valid   (w_any_valid),
    .i_busy        (w_busy),
    .o_active_ok   (w_act),
    .o_ret_en      (ram_ret_en),
    .o_sleep_en    (ram_sleep_en),
    .o_pwr_state   (pwr_state)
  );

endmodule
